// File: rtl/reorder_buffer.sv
// reorder_buffer: circular reorder buffer sitting between dispatch and the in-order
// commit stage. Entries are allocated at the tail on dispatch and filled in from CDB
// broadcasts. The oldest entry is presented at the head and retired when ready.
// A squash empties the buffer in one cycle.
//
// Entry vector layout (dispatch_entry / head_entry), MSB first:
//   [72]    valid
//   [71:67] dest_reg
//   [66]    wr_mem     (entry is a store; CDB also supplies dest_addr)
//   [65:64] mem_size
//   [63:32] value      (result or store data)
//   [31:0]  dest_addr  (store address)
module reorder_buffer #(
  parameter int ROB_SIZE = 8,
  parameter int TAG_W    = $clog2(ROB_SIZE),
  localparam int ENTRY_W = 73
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               dispatch_valid,
  input  logic [ENTRY_W-1:0] dispatch_entry,
  output logic [TAG_W-1:0]   dispatch_tag,
  output logic               rob_full,
  output logic               rob_empty,
  output logic [TAG_W:0]     rob_count,
  input  logic               cdb_valid,
  input  logic [TAG_W-1:0]   cdb_tag,
  input  logic [31:0]        cdb_value,
  input  logic [31:0]        cdb_addr,
  input  logic               commit_stall,
  input  logic               squash,
  output logic [ENTRY_W-1:0] head_entry,
  output logic               head_ready,
  output logic [TAG_W-1:0]   commit_rob_tag
);

  typedef struct packed {
    logic        valid;
    logic [4:0]  dest_reg;
    logic        wr_mem;
    logic [1:0]  mem_size;
    logic [31:0] value;
    logic [31:0] dest_addr;
  } rob_entry_t;

  localparam logic [TAG_W:0] FULL_COUNT = (TAG_W+1)'(ROB_SIZE);

  rob_entry_t            entries_q [ROB_SIZE];
  rob_entry_t            entries_d [ROB_SIZE];
  logic [ROB_SIZE-1:0]   ready_q, ready_d;
  logic [TAG_W-1:0]      head_q, head_d;
  logic [TAG_W-1:0]      tail_q, tail_d;
  logic [TAG_W:0]        count_q, count_d;

  rob_entry_t            disp_in;
  rob_entry_t            head_q_entry;
  logic                  dispatch_fire;
  logic                  commit_fire;

  // Only dest_reg / wr_mem / mem_size are taken from the dispatch vector.
  logic                  unused_dispatch_bits;
  assign unused_dispatch_bits = ^{disp_in.valid, disp_in.value, disp_in.dest_addr};

  assign disp_in      = rob_entry_t'(dispatch_entry);
  assign head_q_entry = entries_q[head_q];

  // Status outputs come straight from registered state (no same-cycle bypass).
  assign rob_full       = (count_q == FULL_COUNT);
  assign rob_empty      = (count_q == '0);
  assign rob_count      = count_q;
  assign dispatch_tag   = tail_q;
  assign commit_rob_tag = head_q;
  assign head_entry     = head_q_entry;
  assign head_ready     = head_q_entry.valid && ready_q[head_q] && !commit_stall;

  // A commit happens exactly when the commit stage sees head_ready.
  assign dispatch_fire = dispatch_valid && !rob_full;
  assign commit_fire   = head_ready;

  // Next-state: squash wins outright; otherwise CDB, commit and dispatch each act
  // on their own entry. CDB cannot hit the dispatch slot since that slot is invalid.
  always_comb begin
    for (int i = 0; i < ROB_SIZE; i++) begin
      entries_d[i] = entries_q[i];
    end
    ready_d = ready_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (squash) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        entries_d[i].valid = 1'b0;
      end
      ready_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (cdb_valid && entries_q[cdb_tag].valid) begin
        entries_d[cdb_tag].value = cdb_value;
        if (entries_q[cdb_tag].wr_mem) begin
          entries_d[cdb_tag].dest_addr = cdb_addr;
        end
        ready_d[cdb_tag] = 1'b1;
      end

      if (commit_fire) begin
        entries_d[head_q].valid = 1'b0;
        ready_d[head_q]         = 1'b0;
        head_d                  = head_q + 1'b1;
      end

      if (dispatch_fire) begin
        entries_d[tail_q].valid     = 1'b1;
        entries_d[tail_q].dest_reg  = disp_in.dest_reg;
        entries_d[tail_q].wr_mem    = disp_in.wr_mem;
        entries_d[tail_q].mem_size  = disp_in.mem_size;
        entries_d[tail_q].value     = '0;
        entries_d[tail_q].dest_addr = '0;
        ready_d[tail_q]             = 1'b0;
        tail_d                      = tail_q + 1'b1;
      end

      case ({dispatch_fire, commit_fire})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; reset clears every field, not just the valid bits.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        entries_q[i] <= '0;
      end
      ready_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        entries_q[i] <= entries_d[i];
      end
      ready_q <= ready_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed scenarios plus random traffic, checked every cycle
// against an in-order queue model of the buffer contents.
module tb_reorder_buffer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        dispatch_valid;
  logic [72:0] dispatch_entry;
  logic [2:0]  dispatch_tag;
  logic        rob_full, rob_empty;
  logic [3:0]  rob_count;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [31:0] cdb_value, cdb_addr;
  logic        commit_stall, squash;
  logic [72:0] head_entry;
  logic        head_ready;
  logic [2:0]  commit_rob_tag;

  always #5 clock = ~clock;

  reorder_buffer dut (
    .clock          (clock),
    .reset          (reset),
    .dispatch_valid (dispatch_valid),
    .dispatch_entry (dispatch_entry),
    .dispatch_tag   (dispatch_tag),
    .rob_full       (rob_full),
    .rob_empty      (rob_empty),
    .rob_count      (rob_count),
    .cdb_valid      (cdb_valid),
    .cdb_tag        (cdb_tag),
    .cdb_value      (cdb_value),
    .cdb_addr       (cdb_addr),
    .commit_stall   (commit_stall),
    .squash         (squash),
    .head_entry     (head_entry),
    .head_ready     (head_ready),
    .commit_rob_tag (commit_rob_tag)
  );

  // Reference model: live instructions in program order, oldest first.
  typedef struct {
    int          tag;
    logic [4:0]  dest;
    logic        wm;
    logic [1:0]  ms;
    logic [31:0] val;
    logic [31:0] addr;
    bit          rdy;
  } mentry_t;

  mentry_t mq[$];
  int      m_tail = 0;
  int      n_cmp  = 0;
  int      n_bad  = 0;

  task automatic check_val(input string tag, input logic [72:0] obs, input logic [72:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [72:0] pack(input logic v, input logic [4:0] d, input logic wm,
                                       input logic [1:0] ms, input logic [31:0] val,
                                       input logic [31:0] a);
    return {v, d, wm, ms, val, a};
  endfunction

  task automatic idle();
    dispatch_valid = 1'b0;
    dispatch_entry = '0;
    cdb_valid      = 1'b0;
    cdb_tag        = '0;
    cdb_value      = '0;
    cdb_addr       = '0;
    commit_stall   = 1'b0;
    squash         = 1'b0;
  endtask

  task automatic set_dispatch(input logic [4:0] d, input logic wm, input logic [1:0] ms);
    dispatch_valid = 1'b1;
    // junk in the ignored fields must not leak into the buffer
    dispatch_entry = pack(1'($urandom), d, wm, ms, $urandom, $urandom);
  endtask

  task automatic set_cdb(input int t, input logic [31:0] v, input logic [31:0] a);
    cdb_valid = 1'b1;
    cdb_tag   = 3'(t);
    cdb_value = v;
    cdb_addr  = a;
  endtask

  function automatic int m_head();
    return (m_tail - mq.size()) & 7;
  endfunction

  // Compare every output against the model under the currently driven inputs.
  task automatic check_outputs();
    logic exp_hr;
    exp_hr = (mq.size() > 0) && mq[0].rdy && !commit_stall;
    check_val("dispatch_tag", dispatch_tag, 73'(m_tail));
    check_val("rob_count", rob_count, 73'(mq.size()));
    check_val("rob_full", rob_full, 73'(mq.size() == 8));
    check_val("rob_empty", rob_empty, 73'(mq.size() == 0));
    check_val("head_ready", head_ready, exp_hr);
    check_val("commit_rob_tag", commit_rob_tag, 73'(m_head()));
    if (mq.size() > 0)
      check_val("head_entry", head_entry,
                pack(1'b1, mq[0].dest, mq[0].wm, mq[0].ms, mq[0].val, mq[0].addr));
    else
      check_val("head_valid", head_entry[72], 73'(0));
  endtask

  // Advance the model by one clock edge using the inputs that were applied.
  task automatic model_update();
    bit      full, hr;
    mentry_t e;
    if (!reset || squash) begin
      mq.delete();
      m_tail = 0;
      return;
    end
    full = (mq.size() == 8);
    hr   = (mq.size() > 0) && mq[0].rdy && !commit_stall;
    if (cdb_valid) begin
      foreach (mq[i]) begin
        if (mq[i].tag == int'(cdb_tag)) begin
          mq[i].val = cdb_value;
          if (mq[i].wm) mq[i].addr = cdb_addr;
          mq[i].rdy = 1'b1;
        end
      end
    end
    if (hr) void'(mq.pop_front());
    if (dispatch_valid && !full) begin
      e.tag  = m_tail;
      e.dest = dispatch_entry[71:67];
      e.wm   = dispatch_entry[66];
      e.ms   = dispatch_entry[65:64];
      e.val  = '0;
      e.addr = '0;
      e.rdy  = 1'b0;
      mq.push_back(e);
      m_tail = (m_tail + 1) & 7;
    end
  endtask

  task automatic cycle();
    #1;
    check_outputs();
    @(posedge clock);
    model_update();
    @(negedge clock);
  endtask

  initial begin
    idle();
    #1;
    // reset state
    check_val("rst_empty", rob_empty, 73'(1));
    check_val("rst_full", rob_full, 73'(0));
    check_val("rst_head_ready", head_ready, 73'(0));
    check_val("rst_dispatch_tag", dispatch_tag, 73'(0));
    check_val("rst_commit_tag", commit_rob_tag, 73'(0));
    check_val("rst_head_entry", head_entry, 73'(0));
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;

    // 1: three dispatches get tags 0,1,2
    for (int i = 0; i < 3; i++) begin
      idle();
      set_dispatch(5'(i + 1), 1'b0, 2'd2);
      #1;
      check_val("t1_tag", dispatch_tag, 73'(i));
      cycle();
    end
    idle();
    #1;
    check_val("t1_count", rob_count, 73'(3));
    check_val("t1_head_ready", head_ready, 73'(0));

    // 2: out-of-order completion, in-order commit
    idle(); set_cdb(1, 32'hAA, 32'h1000); cycle();
    idle(); set_cdb(0, 32'h55, 32'h2000); cycle();
    idle();
    #1;
    check_val("t2_head_ready0", head_ready, 73'(1));
    check_val("t2_value0", head_entry[63:32], 73'h55);
    check_val("t2_tag0", commit_rob_tag, 73'(0));
    cycle();
    #1;
    check_val("t2_head_ready1", head_ready, 73'(1));
    check_val("t2_value1", head_entry[63:32], 73'hAA);
    check_val("t2_tag1", commit_rob_tag, 73'(1));
    cycle();

    // 3: fill, overflow drop, commit+dispatch without bypass, wrap
    idle(); squash = 1'b1; cycle();
    for (int i = 0; i < 8; i++) begin
      idle(); set_dispatch(5'(i + 8), 1'(i % 2), 2'(i)); cycle();
    end
    idle();
    #1;
    check_val("t3_full", rob_full, 73'(1));
    set_dispatch(5'd31, 1'b1, 2'd3); cycle();
    idle();
    #1;
    check_val("t3_drop_count", rob_count, 73'(8));
    check_val("t3_drop_tail", dispatch_tag, 73'(0));
    set_cdb(0, 32'h1234_5678, 32'hDEAD_BEE0); cycle();
    idle(); set_dispatch(5'd30, 1'b0, 2'd1); cycle();
    idle();
    #1;
    check_val("t3_nobypass_count", rob_count, 73'(7));
    check_val("t3_wrap_tag", dispatch_tag, 73'(0));
    set_dispatch(5'd29, 1'b1, 2'd0); cycle();
    idle();
    #1;
    check_val("t3_refill_count", rob_count, 73'(8));

    // 4: commit_stall holds the head
    idle(); set_cdb(1, 32'hCAFE, 32'hF00D); cycle();
    for (int i = 0; i < 3; i++) begin
      idle(); commit_stall = 1'b1;
      #1;
      check_val("t4_stall_ready", head_ready, 73'(0));
      check_val("t4_stall_head", commit_rob_tag, 73'(1));
      cycle();
    end
    idle();
    #1;
    check_val("t4_release_ready", head_ready, 73'(1));
    cycle();
    #1;
    check_val("t4_after_head", commit_rob_tag, 73'(2));

    // 5: squash overrides concurrent dispatch and CDB
    idle(); squash = 1'b1; cycle();
    for (int i = 0; i < 5; i++) begin
      idle(); set_dispatch(5'(i), 1'b1, 2'd2); cycle();
    end
    idle(); squash = 1'b1; set_dispatch(5'd7, 1'b0, 2'd0); set_cdb(0, 32'h77, 32'h88); cycle();
    idle();
    #1;
    check_val("t5_count", rob_count, 73'(0));
    check_val("t5_empty", rob_empty, 73'(1));
    check_val("t5_tag", dispatch_tag, 73'(0));
    for (int t = 0; t < 8; t++) begin
      idle(); set_cdb(t, 32'h99, 32'h99); cycle();
    end
    idle();
    #1;
    check_val("t5_invalid_all", head_ready, 73'(0));
    cycle();

    // 6: asynchronous reset between clock edges
    for (int i = 0; i < 4; i++) begin
      idle(); set_dispatch(5'(i + 3), 1'b0, 2'd1); cycle();
    end
    idle();
    #2;
    reset = 1'b0;
    #1;
    check_val("t6_count", rob_count, 73'(0));
    check_val("t6_empty", rob_empty, 73'(1));
    check_val("t6_tag", dispatch_tag, 73'(0));
    check_val("t6_head_ready", head_ready, 73'(0));
    @(posedge clock);
    model_update();
    @(negedge clock);
    reset = 1'b1;

    // random traffic
    for (int n = 0; n < 400; n++) begin
      idle();
      if ($urandom_range(9) < 6)
        set_dispatch(5'($urandom), 1'($urandom), 2'($urandom));
      if ($urandom_range(9) < 6) begin
        if (mq.size() > 0 && $urandom_range(3) != 0)
          set_cdb(mq[$urandom_range(mq.size() - 1)].tag, $urandom, $urandom);
        else
          set_cdb(int'($urandom_range(7)), $urandom, $urandom);
      end
      commit_stall = ($urandom_range(3) == 0);
      squash       = ($urandom_range(49) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
